sine_voice_sched: RTL and testbench
===================================

Name: sine_voice_sched

Overview:
Time-shares one external sine lookup table (501-entry period, 8-bit unsigned, midscale 127) among NUM_VOICES independent voices.
- On each sample_tick, sequences one LUT fetch per voice and advances that voice's fixed-point phase accumulator.
- Sums the fetched samples and emits one averaged 8-bit mixed sample.
- Sits between the audio sample-rate timer and the DAC/PWM output stage; voice pitch comes from the cfg_* register port.

Parameters:
NUM_VOICES, 4, voice count; power of two, 1..8
FRAC, 6, fractional bits of the phase accumulator
PERIOD, 501, LUT entries per sine period (addresses 0..500)

Ports:
s_clk  in  1  system clock
s_rst_n  in  1  asynchronous active-low reset
sample_tick  in  1  one-cycle pulse requesting a new mixed sample
cfg_we  in  1  config write strobe
cfg_voice  in  $clog2(NUM_VOICES) (min 1)  target voice of the write
cfg_inc  in  10+FRAC  phase increment per sample
cfg_en  in  1  voice enable
lut_addr  out  10  LUT address; 1-cycle read latency
lut_data  in  8  LUT sample
mix_out  out  8  mixed sample
mix_valid  out  1  one-cycle pulse: mix_out updated
busy  out  1  sweep in progress
overrun  out  1  sticky: sample_tick arrived while not IDLE

Behaviour:
- Reset state: FSM=IDLE, all phases 0, all inc 0, all enables 0, lut_addr 0, mix_out 127, mix_valid 0, busy 0, overrun 0.
- Phase: PHASE_W = 10+FRAC, unsigned. Wrap limit L = PERIOD<<FRAC (32064 at defaults).
  - Advance: next = phase+inc; if next >= L then next-L.
  - cfg_inc >= L saturates to L-1 on write.
- FSM:
  - IDLE: sample_tick accepted -> FETCH, v=0, sum cleared.
  - FETCH: lut_addr = phase[v] >> FRAC -> ACCUM.
  - ACCUM: sum += lut_data if voice v enabled, else += 127; advance phase[v] if enabled. Next state is FETCH with v+1, or OUT after the last voice.
  - OUT: mix_out <= sum >> $clog2(NUM_VOICES); mix_valid=1 for one cycle -> IDLE.
- Sum width: 8+$clog2(NUM_VOICES). Truncate on output.
- Latency: mix_valid is high in the cycle following the (2*NUM_VOICES+1)th edge after the edge sampling sample_tick (9 at defaults).
- busy = (state != IDLE).
- Overrun: sample_tick while busy (including the OUT cycle) is dropped and sets overrun. overrun is cleared only by reset.
- Config writes apply at the clock edge, in any state.
  - cfg_en=0: zeroes that voice's phase. This takes priority over a simultaneous advance.
  - New inc is first used at that voice's next advance. An advance on the same edge uses the old value.
  - Re-enabling starts from phase 0.
- lut_addr holds its last value outside FETCH.
- Reset asserted mid-sweep: immediate return to reset state; no mix_valid for the aborted sweep.

Optional Feature:
SINE_SCHED_OVR_CNT_EN
- Defined: adds output ovr_count [7:0], counting dropped ticks and saturating at 255; reset 0. overrun = (ovr_count != 0).
- Undefined: no ovr_count port; overrun is a single sticky flag.

Decomposition:
- Package sine_sched_pkg holds:
  - constants PERIOD, FRAC, PHASE_W, MIDSCALE=127, LUT_AW=10
  - typedef phase_t
  - enum sched_state_t {IDLE, FETCH, ACCUM, OUT}
- One sub-module: sine_phase_wrap, a combinational modulo-L adder (phase, inc -> next). Instantiated once; the FSM shares it across voices.

Test Plan:
- Reset: assert s_rst_n=0 mid-operation -> mix_out=127, busy=0, mix_valid=0, overrun=0, lut_addr=0.
- Single voice: voice0 en, inc=64, others disabled; 5 ticks spaced 20 cycles.
  - voice0 lut_addr 0,1,2,3,4.
  - mix_out=(lut[k]+381)>>2; tick0 -> (127+381)>>2 = 127.
  - mix_valid exactly 9 cycles after each tick.
- Wrap: voice0 inc=32000 -> addresses 0, 500, 499 (phase 0, 32000, 31936). cfg_inc=40000 -> stored 32063.
- Overrun: tick at t, second tick at t+3 -> one mix_valid, overrun=1. With macro, ovr_count=1; 300 more overlapping ticks -> 255.
- Disable collision: cfg_we cfg_en=0 for voice1 on the same edge as its ACCUM -> phase1=0, and later sweeps use 127 for voice1.
- All four voices en, inc=64,128,192,256; 3 ticks -> per-sweep lut_addr sequence {0,0,0,0},{1,2,3,4},{2,4,6,8}; mix_out matches the model average.

Source files
------------

// File: rtl/sine_sched_pkg.sv
// Shared constants, phase type and scheduler state encoding for the sine voice scheduler.
package sine_sched_pkg;

  localparam int PERIOD   = 501;
  localparam int FRAC     = 6;
  localparam int PHASE_W  = 10 + FRAC;
  localparam int MIDSCALE = 127;
  localparam int LUT_AW   = 10;

  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ACCUM,
    OUT
  } sched_state_t;

endpackage

// File: rtl/sine_phase_wrap.sv
// Combinational modulo-LIMIT phase adder; both inputs are assumed below LIMIT.
module sine_phase_wrap #(
  parameter int PHASE_W = sine_sched_pkg::PHASE_W,
  parameter int LIMIT   = sine_sched_pkg::PERIOD << sine_sched_pkg::FRAC
) (
  input  logic [PHASE_W-1:0] phase_i,
  input  logic [PHASE_W-1:0] inc_i,
  output logic [PHASE_W-1:0] next_o
);

  logic [PHASE_W:0] sum;

  always_comb begin
    sum = {1'b0, phase_i} + {1'b0, inc_i};
    if (sum >= (PHASE_W+1)'(LIMIT)) begin
      next_o = PHASE_W'(sum - (PHASE_W+1)'(LIMIT));
    end else begin
      next_o = sum[PHASE_W-1:0];
    end
  end

endmodule

// File: rtl/sine_voice_sched.sv
// Time-shares one sine LUT among NUM_VOICES phase accumulators and emits their averaged mix.
// Optional SINE_SCHED_OVR_CNT_EN adds a saturating dropped-tick counter output ovr_count.
module sine_voice_sched #(
  parameter int NUM_VOICES = 4,
  parameter int FRAC       = sine_sched_pkg::FRAC,
  parameter int PERIOD     = sine_sched_pkg::PERIOD,
  localparam int VW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
  localparam int PW        = 10 + FRAC
) (
  input  logic                              s_clk,
  input  logic                              s_rst_n,
  input  logic                              sample_tick,
  input  logic                              cfg_we,
  input  logic [VW-1:0]                     cfg_voice,
  input  logic [PW-1:0]                     cfg_inc,
  input  logic                              cfg_en,
  output logic [sine_sched_pkg::LUT_AW-1:0] lut_addr,
  input  logic [7:0]                        lut_data,
  output logic [7:0]                        mix_out,
  output logic                              mix_valid,
  output logic                              busy,
  output logic                              overrun
`ifdef SINE_SCHED_OVR_CNT_EN
  ,
  output logic [7:0]                        ovr_count
`endif
);
  import sine_sched_pkg::*;

  localparam int SHIFT = $clog2(NUM_VOICES);
  localparam int SW    = 8 + SHIFT;
  localparam int LIM   = PERIOD << FRAC;
  localparam logic [PW-1:0] INC_MAX = PW'(LIM - 1);

  function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] inc);
    return (int'(inc) >= LIM) ? INC_MAX : inc;
  endfunction

  sched_state_t          state_q, state_d;
  logic [VW-1:0]         v_q;
  logic [SW-1:0]         sum_q;
  logic [PW-1:0]         phase_q [NUM_VOICES];
  logic [PW-1:0]         inc_q   [NUM_VOICES];
  logic [NUM_VOICES-1:0] en_q;
  logic [9:0]            lut_addr_q;
  logic [7:0]            mix_out_q;
  logic                  mix_valid_q;
  logic [PW-1:0]         next_phase;
  logic [7:0]            samp;
  logic                  last_voice;
  logic                  tick_drop;

  sine_phase_wrap #(
    .PHASE_W (PW),
    .LIMIT   (LIM)
  ) u_wrap (
    .phase_i (phase_q[v_q]),
    .inc_i   (inc_q[v_q]),
    .next_o  (next_phase)
  );

  assign last_voice = (int'(v_q) == NUM_VOICES - 1);
  assign tick_drop  = sample_tick && (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign lut_addr   = lut_addr_q;
  assign mix_out    = mix_out_q;
  assign mix_valid  = mix_valid_q;

  always_comb begin
    samp = en_q[v_q] ? lut_data : 8'(MIDSCALE);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_tick) state_d = FETCH;
      FETCH:   state_d = ACCUM;
      ACCUM:   state_d = last_voice ? OUT : FETCH;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sweep datapath: FETCH registers the LUT address, ACCUM consumes the returned sample.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      v_q         <= '0;
      sum_q       <= '0;
      lut_addr_q  <= '0;
      mix_out_q   <= 8'(MIDSCALE);
      mix_valid_q <= 1'b0;
    end else begin
      mix_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sample_tick) begin
            v_q   <= '0;
            sum_q <= '0;
          end
        end
        FETCH: lut_addr_q <= phase_q[v_q][PW-1:FRAC];
        ACCUM: begin
          sum_q <= sum_q + SW'(samp);
          v_q   <= v_q + VW'(1);
        end
        OUT: begin
          mix_out_q   <= 8'(sum_q >> SHIFT);
          mix_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A disabling config write overrides an advance landing on the same edge.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i] <= '0;
        inc_q[i]   <= '0;
      end
      en_q <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (state_q == ACCUM && int'(v_q) == i && en_q[i]) begin
          phase_q[i] <= next_phase;
        end
        if (cfg_we && int'(cfg_voice) == i) begin
          inc_q[i] <= sat_inc(cfg_inc);
          en_q[i]  <= cfg_en;
          if (!cfg_en) phase_q[i] <= '0;
        end
      end
    end
  end

`ifdef SINE_SCHED_OVR_CNT_EN
  logic [7:0] ovr_cnt_q;

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      ovr_cnt_q <= '0;
    end else if (tick_drop && ovr_cnt_q != 8'hFF) begin
      ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end

  assign ovr_count = ovr_cnt_q;
  assign overrun   = (ovr_cnt_q != 8'd0);
`else
  logic overrun_q;

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      overrun_q <= 1'b0;
    end else if (tick_drop) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_sine_voice_sched.sv
// Randomized self-checking bench for sine_voice_sched against a sweep-level reference model.
`timescale 1ns/1ps
module tb_sine_voice_sched;

  localparam int NV     = 4;
  localparam int FRAC   = 6;
  localparam int PERIOD = 501;
  localparam int L      = PERIOD << FRAC;
  localparam int PW     = 10 + FRAC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          cfg_we = 1'b0;
  logic          cfg_en = 1'b0;
  logic [1:0]    cfg_voice = '0;
  logic [PW-1:0] cfg_inc = '0;
  logic [9:0]    lut_addr;
  logic [7:0]    lut_data;
  logic [7:0]    mix_out;
  logic          mix_valid;
  logic          busy;
  logic          overrun;
`ifdef SINE_SCHED_OVR_CNT_EN
  logic [7:0]    ovr_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] lut [0:PERIOD-1];
  int m_phase [NV];
  int m_inc   [NV];
  bit m_en    [NV];
  int exp_addr[NV];
  int exp_mix;

  always #5 clk = ~clk;

  assign lut_data = (lut_addr < 10'(PERIOD)) ? lut[lut_addr] : 8'h00;

  sine_voice_sched #(
    .NUM_VOICES (NV),
    .FRAC       (FRAC),
    .PERIOD     (PERIOD)
  ) dut (
    .s_clk       (clk),
    .s_rst_n     (rst_n),
    .sample_tick (tick),
    .cfg_we      (cfg_we),
    .cfg_voice   (cfg_voice),
    .cfg_inc     (cfg_inc),
    .cfg_en      (cfg_en),
    .lut_addr    (lut_addr),
    .lut_data    (lut_data),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .overrun     (overrun)
`ifdef SINE_SCHED_OVR_CNT_EN
    ,
    .ovr_count   (ovr_count)
`endif
  );

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = 0;
      m_inc[v]   = 0;
      m_en[v]    = 0;
    end
  endtask

  task automatic model_cfg(input int v, input int inc, input bit en);
    m_inc[v] = (inc >= L) ? L - 1 : inc;
    m_en[v]  = en;
    if (!en) m_phase[v] = 0;
  endtask

  // One sweep: each voice reads sine[phase/2^FRAC]; disabled voices contribute midscale.
  task automatic model_sweep();
    int s;
    s = 0;
    for (int v = 0; v < NV; v++) begin
      exp_addr[v] = m_phase[v] / (1 << FRAC);
      s += m_en[v] ? int'(lut[exp_addr[v]]) : 127;
      if (m_en[v]) m_phase[v] = (m_phase[v] + m_inc[v]) % L;
    end
    exp_mix = s / NV;
  endtask

  task automatic cfg_write(input int v, input int inc, input bit en);
    @(negedge clk);
    cfg_we = 1'b1; cfg_voice = 2'(v); cfg_inc = PW'(inc); cfg_en = en;
    @(negedge clk);
    cfg_we = 1'b0;
    model_cfg(v, inc, en);
  endtask

  task automatic do_sweep(input bit pre, input bit chain, input int inj_c, input int inj_v,
                          input int inj_inc, input bit inj_en);
    model_sweep();
    if (!pre) begin
      @(negedge clk);
      tick = 1'b1;
    end
    @(negedge clk);
    tick = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c % 2 == 1 && c < 9) begin
        checks++;
        if (lut_addr !== 10'(exp_addr[c/2])) begin
          errors++;
          $display("FAIL lut_addr voice%0d: got %0d, expected %0d", c/2, lut_addr, exp_addr[c/2]);
        end
      end
      checks++;
      if (mix_valid !== 1'(c == 9)) begin
        errors++;
        $display("FAIL mix_valid cycle %0d: got %0b, expected %0b", c, mix_valid, c == 9);
      end
      checks++;
      if (busy !== 1'(c < 9)) begin
        errors++;
        $display("FAIL busy cycle %0d: got %0b, expected %0b", c, busy, c < 9);
      end
      if (c == 9) begin
        checks++;
        if (mix_out !== 8'(exp_mix)) begin
          errors++;
          $display("FAIL mix_out: got %0d, expected %0d", mix_out, exp_mix);
        end
      end
      if (inj_c == c) cfg_we = 1'b0;
      if (inj_c == c + 1) begin
        cfg_we = 1'b1; cfg_voice = 2'(inj_v); cfg_inc = PW'(inj_inc); cfg_en = inj_en;
      end
      if (chain && c == 9) tick = 1'b1;
    end
    if (inj_c > 0) model_cfg(inj_v, inj_inc, inj_en);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (mix_out !== 8'd127) begin
      errors++; $display("FAIL %s mix_out: got %0d, expected 127", tag, mix_out);
    end
    checks++;
    if (busy !== 1'b0 || mix_valid !== 1'b0) begin
      errors++; $display("FAIL %s busy/mix_valid: got %0b/%0b, expected 0/0", tag, busy, mix_valid);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL %s overrun: got %0b, expected 0", tag, overrun);
    end
    checks++;
    if (lut_addr !== 10'd0) begin
      errors++; $display("FAIL %s lut_addr: got %0d, expected 0", tag, lut_addr);
    end
`ifdef SINE_SCHED_OVR_CNT_EN
    checks++;
    if (ovr_count !== 8'd0) begin
      errors++; $display("FAIL %s ovr_count: got %0d, expected 0", tag, ovr_count);
    end
`endif
  endtask

  task automatic test_power_on();
    repeat (3) @(negedge clk);
    check_reset_outputs("power_on");
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_voice();
    cfg_write(0, 64, 1'b1);
    for (int k = 0; k < 5; k++) begin
      do_sweep(1'b0, 1'b0, 0, 0, 0, 1'b0);
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    cfg_write(0, 0, 1'b0);
    cfg_write(0, 32000, 1'b1);
    repeat (3) do_sweep(1'b0, 1'b0, 0, 0, 0, 1'b0);
    cfg_write(0, 0, 1'b0);
    cfg_write(0, 40000, 1'b1);
    repeat (3) do_sweep(1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_disable_collision();
    cfg_write(1, 64, 1'b1);
    do_sweep(1'b0, 1'b0, 0, 0, 0, 1'b0);
    do_sweep(1'b0, 1'b0, 4, 1, 64, 1'b0);
    repeat (2) do_sweep(1'b0, 1'b0, 0, 0, 0, 1'b0);
    cfg_write(1, 64, 1'b1);
    repeat (2) do_sweep(1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_all_voices();
    for (int v = 0; v < NV; v++) cfg_write(v, 0, 1'b0);
    for (int v = 0; v < NV; v++) cfg_write(v, 64 * (v + 1), 1'b1);
    repeat (3) begin
      do_sweep(1'b0, 1'b0, 0, 0, 0, 1'b0);
      repeat (5) @(negedge clk);
    end
    for (int it = 0; it < 10; it++) begin
      for (int v = 0; v < NV; v++) begin
        if ($urandom_range(0, 1) == 1)
          cfg_write(v, int'($urandom_range(0, 65535)), $urandom_range(0, 3) != 0);
      end
      repeat (1 + $urandom_range(0, 2)) do_sweep(1'b0, 1'b0, 0, 0, 0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    do_sweep(1'b0, 1'b1, 0, 0, 0, 1'b0);
    do_sweep(1'b1, 1'b1, 0, 0, 0, 1'b0);
    do_sweep(1'b1, 1'b0, 0, 0, 0, 1'b0);
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL back_to_back overrun: got %0b, expected 0", overrun);
    end
  endtask

  task automatic test_overrun();
    int nvalid;
    logic [7:0] last_mix;
    nvalid = 0;
    last_mix = 8'd0;
    model_sweep();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_early: got %0b, expected 0", overrun);
    end
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (mix_valid === 1'b1) begin
        nvalid++;
        last_mix = mix_out;
      end
    end
    checks++;
    if (nvalid != 1) begin
      errors++; $display("FAIL overrun_valid_count: got %0d, expected 1", nvalid);
    end
    checks++;
    if (last_mix !== 8'(exp_mix)) begin
      errors++; $display("FAIL overrun_mix_out: got %0d, expected %0d", last_mix, exp_mix);
    end
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL overrun_flag/busy: got %0b/%0b, expected 1/0", overrun, busy);
    end
`ifdef SINE_SCHED_OVR_CNT_EN
    checks++;
    if (ovr_count !== 8'd1) begin
      errors++; $display("FAIL ovr_count_one: got %0d, expected 1", ovr_count);
    end
`endif
    tick = 1'b1;
    repeat (300) @(negedge clk);
    tick = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_sticky: got %0b, expected 1", overrun);
    end
`ifdef SINE_SCHED_OVR_CNT_EN
    checks++;
    if (ovr_count !== 8'd255) begin
      errors++; $display("FAIL ovr_count_sat: got %0d, expected 255", ovr_count);
    end
`endif
  endtask

  task automatic test_reset();
    int nvalid;
    nvalid = 0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (mix_valid === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_abort: mix_valid pulses %0d busy %0b, expected 0 and 0", nvalid, busy);
    end
    model_reset();
  endtask

  task automatic test_overrun_out();
    model_sweep();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (8) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checks++;
    if (mix_valid !== 1'b1 || mix_out !== 8'(exp_mix)) begin
      errors++; $display("FAIL out_tick_mix: got valid %0b mix %0d, expected 1 and %0d", mix_valid, mix_out, exp_mix);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL out_tick_overrun: got %0b, expected 1", overrun);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL out_tick_dropped busy: got %0b, expected 0", busy);
    end
  endtask

  initial begin
    for (int k = 0; k < PERIOD; k++)
      lut[k] = 8'($rtoi(127.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 501.0) + 0.5));
    model_reset();
    test_power_on();
    test_single_voice();
    test_wrap();
    test_disable_collision();
    test_all_voices();
    test_back_to_back();
    test_overrun();
    test_reset();
    test_overrun_out();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
